// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the button gesture block.
package btn_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_GAP,
    S_HELD
  } ch_state_e;

  function automatic int timer_w(
    input int hold_us,
    input int gap_us,
    input int rep_us
  );
    int m;
    m = hold_us;
    if (gap_us > m) m = gap_us;
    if (rep_us > m) m = rep_us;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/btn_gesture_ch.sv
// One button channel: synchroniser, tick-based debouncer and gesture FSM.
module btn_gesture_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_US = 10_000,
  parameter int HOLD_US     = 700_000,
  parameter int GAP_US      = 150_000,
  parameter int MAX_TAPS    = 3,
  parameter int REPEAT_US   = 200_000
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       tick_i,
  input  logic       btn_i,
  input  logic       repeat_en_i,
  output logic       tap_valid_o,
  output logic [1:0] tap_count_o,
  output logic       long_start_o,
  output logic       long_repeat_o,
  output logic       long_end_o,
  output logic       busy_o
);

  localparam int TW = timer_w(HOLD_US, GAP_US, REPEAT_US);
  localparam int DW = $clog2(DEBOUNCE_US + 1);

  localparam logic [TW-1:0] HOLD_T = TW'(HOLD_US);
  localparam logic [TW-1:0] GAP_T  = TW'(GAP_US);
  localparam logic [TW-1:0] REP_T  = TW'(REPEAT_US);
  localparam logic [DW-1:0] DBC_LAST = DW'(DEBOUNCE_US - 1);
  localparam logic [1:0]    TAPS_MAX = 2'(MAX_TAPS);

  logic          sync1_q;
  logic          sync2_q;
  logic          lvl_q;
  logic          lvl_prev_q;
  logic [DW-1:0] dbc_q;
  logic          prs;
  logic          rls;

  ch_state_e     state_q;
  logic [1:0]    taps_q;
  logic [TW-1:0] tmr_q;
  logic [TW-1:0] tmr_d;

  // Debounce counts ticks of disagreement; any agreement restarts it.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
      dbc_q      <= '0;
    end else begin
      sync1_q    <= btn_i;
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl_q;
      if (sync2_q == lvl_q) begin
        dbc_q <= '0;
      end else if (tick_i) begin
        if (dbc_q == DBC_LAST) begin
          lvl_q <= sync2_q;
          dbc_q <= '0;
        end else begin
          dbc_q <= dbc_q + 1'b1;
        end
      end
    end
  end

  assign prs   = lvl_q & ~lvl_prev_q;
  assign rls   = ~lvl_q & lvl_prev_q;
  assign tmr_d = (tick_i && (tmr_q != '1)) ? tmr_q + 1'b1 : tmr_q;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q       <= S_IDLE;
      taps_q        <= '0;
      tmr_q         <= '0;
      tap_valid_o   <= 1'b0;
      tap_count_o   <= '0;
      long_start_o  <= 1'b0;
      long_repeat_o <= 1'b0;
      long_end_o    <= 1'b0;
    end else begin
      tap_valid_o   <= 1'b0;
      long_start_o  <= 1'b0;
      long_repeat_o <= 1'b0;
      long_end_o    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (prs) begin
            state_q <= S_PRESSED;
            taps_q  <= 2'd1;
            tmr_q   <= '0;
          end
        end
        S_PRESSED: begin
          if (rls) begin
            if (taps_q == TAPS_MAX) begin
              tap_valid_o <= 1'b1;
              tap_count_o <= taps_q;
              state_q     <= S_IDLE;
            end else begin
              state_q <= S_GAP;
              tmr_q   <= '0;
            end
          end else if (tmr_q >= HOLD_T) begin
            state_q      <= S_HELD;
            long_start_o <= 1'b1;
            taps_q       <= '0;
            tmr_q        <= '0;
          end else begin
            tmr_q <= tmr_d;
          end
        end
        // A press on the expiry cycle still extends the sequence.
        S_GAP: begin
          if (prs) begin
            state_q <= S_PRESSED;
            taps_q  <= taps_q + 2'd1;
            tmr_q   <= '0;
          end else if (tmr_q >= GAP_T) begin
            tap_valid_o <= 1'b1;
            tap_count_o <= taps_q;
            state_q     <= S_IDLE;
          end else begin
            tmr_q <= tmr_d;
          end
        end
        S_HELD: begin
          if (rls) begin
            long_end_o <= 1'b1;
            state_q    <= S_IDLE;
          end else if (!repeat_en_i) begin
            tmr_q <= '0;
          end else if (tmr_q >= REP_T) begin
            long_repeat_o <= 1'b1;
            tmr_q         <= '0;
          end else begin
            tmr_q <= tmr_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != S_IDLE);

endmodule

// File: rtl/btn_gesture_multi.sv
// Multi-channel button gesture detector: shared us tick, one
// synchroniser/debouncer/FSM per channel.
module btn_gesture_multi #(
  parameter int N_CH        = 4,
  parameter int CLK_MHZ     = 125,
  parameter int DEBOUNCE_US = 10_000,
  parameter int HOLD_US     = 700_000,
  parameter int GAP_US      = 150_000,
  parameter int MAX_TAPS    = 3,
  parameter int REPEAT_US   = 200_000
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic [N_CH-1:0]   btn,
  input  logic [N_CH-1:0]   repeat_en,
  output logic [N_CH-1:0]   tap_valid,
  output logic [2*N_CH-1:0] tap_count,
  output logic [N_CH-1:0]   long_start,
  output logic [N_CH-1:0]   long_repeat,
  output logic [N_CH-1:0]   long_end,
  output logic [N_CH-1:0]   busy
);

  localparam int CW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_MHZ - 1);

  logic [CW-1:0] div_q;
  logic          tick;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      div_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign tick = (div_q == DIV_LAST);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_gesture_ch #(
      .DEBOUNCE_US (DEBOUNCE_US),
      .HOLD_US     (HOLD_US),
      .GAP_US      (GAP_US),
      .MAX_TAPS    (MAX_TAPS),
      .REPEAT_US   (REPEAT_US)
    ) u_ch (
      .clk           (clk),
      .reset_p       (reset_p),
      .tick_i        (tick),
      .btn_i         (btn[i]),
      .repeat_en_i   (repeat_en[i]),
      .tap_valid_o   (tap_valid[i]),
      .tap_count_o   (tap_count[2*i +: 2]),
      .long_start_o  (long_start[i]),
      .long_repeat_o (long_repeat[i]),
      .long_end_o    (long_end[i]),
      .busy_o        (busy[i])
    );
  end

endmodule

// File: tb/tb_btn_gesture_multi.sv
// Scoreboard bench for btn_gesture_multi: expected pulses with cycle
// windows are queued per channel as stimulus is driven.
`timescale 1ns/1ps
module tb_btn_gesture_multi;

  localparam int N_CH = 2;
  localparam int K_TAP = 0;
  localparam int K_LS = 1;
  localparam int K_LR = 2;
  localparam int K_LE = 3;
  localparam int K_NONE = 4;

  typedef struct {
    int kind;
    int cnt;
    int lo;
    int hi;
  } sb_t;

  logic              clk = 1'b0;
  logic              reset_p;
  logic [N_CH-1:0]   btn;
  logic [N_CH-1:0]   repeat_en;
  logic [N_CH-1:0]   tap_valid;
  logic [2*N_CH-1:0] tap_count;
  logic [N_CH-1:0]   long_start;
  logic [N_CH-1:0]   long_repeat;
  logic [N_CH-1:0]   long_end;
  logic [N_CH-1:0]   busy;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  sb_t  sbq[N_CH][$];
  logic bounce_mode = 1'b0;
  logic busy_seen = 1'b0;
  logic [3:0] pv;

  btn_gesture_multi #(
    .N_CH(N_CH), .CLK_MHZ(2), .DEBOUNCE_US(2), .HOLD_US(20),
    .GAP_US(10), .MAX_TAPS(3), .REPEAT_US(5)
  ) dut (
    .clk(clk), .reset_p(reset_p), .btn(btn), .repeat_en(repeat_en),
    .tap_valid(tap_valid), .tap_count(tap_count),
    .long_start(long_start), .long_repeat(long_repeat),
    .long_end(long_end), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic push(input int c, input int k, input int n,
                      input int lo, input int hi);
    sb_t e;
    e.kind = k; e.cnt = n; e.lo = lo; e.hi = hi;
    sbq[c].push_back(e);
  endtask

  task automatic score(input int c, input int k);
    sb_t e;
    if (sbq[c].size() == 0) begin
      check($sformatf("unexpected_ch%0d", c), k, K_NONE);
      return;
    end
    e = sbq[c].pop_front();
    check($sformatf("kind_ch%0d", c), k, e.kind);
    if (k == K_TAP)
      check($sformatf("count_ch%0d", c), int'(tap_count[2*c +: 2]), e.cnt);
    check($sformatf("cycle_ch%0d", c), cyc, clampi(cyc, e.lo, e.hi));
  endtask

  always @(negedge clk) begin
    if (!reset_p) begin
      for (int c = 0; c < N_CH; c++) begin
        pv = {long_end[c], long_repeat[c], long_start[c], tap_valid[c]};
        for (int k = 0; k < 4; k++)
          if (pv[k]) score(c, k);
      end
      if (bounce_mode && busy != '0) busy_seen = 1'b1;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic us(input int n);
    cycles(2 * n);
  endtask

  task automatic wait_q(input string tag, input int budget);
    int n;
    n = 0;
    while ((sbq[0].size() + sbq[1].size()) != 0 && n < budget) begin
      cycles(1);
      n++;
    end
    check({tag, "_pending"}, sbq[0].size() + sbq[1].size(), 0);
  endtask

  task automatic drain(input string tag);
    wait_q(tag, 400);
    cycles(60);
    check({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pulses"},
          int'({tap_valid, long_start, long_repeat, long_end}), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_count"}, int'(tap_count), 0);
  endtask

  // Debounced edge reaches the FSM 5-6 cycles after btn changes.
  task automatic tap_seq(input int c, input int n, input int last_close);
    int r;
    for (int i = 0; i < n; i++) begin
      btn[c] = 1'b1;
      us(5);
      btn[c] = 1'b0;
      r = cyc;
      if (i != n - 1) us(4);
    end
    if (last_close != 0) push(c, K_TAP, n, r + 5, r + 8);
    else push(c, K_TAP, n, r + 25, r + 28);
  endtask

  task automatic long_hold(input int c, input int reps, input int hold);
    int k;
    int q;
    k = cyc;
    btn[c] = 1'b1;
    push(c, K_LS, 0, k + 45, k + 48);
    for (int i = 1; i <= reps; i++)
      push(c, K_LR, 0, k + 45 + 10 * i, k + 48 + 10 * i);
    us(hold);
    q = cyc;
    btn[c] = 1'b0;
    push(c, K_LE, 0, q + 5, q + 8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r;
    reset_p = 1'b1;
    btn = '0;
    repeat_en = '0;
    cycles(4);
    check_zero("reset");
    reset_p = 1'b0;
    cycles(4);

    // single tap, then tap_count must hold
    btn[0] = 1'b1;
    us(8);
    btn[0] = 1'b0;
    r = cyc;
    push(0, K_TAP, 1, r + 25, r + 28);
    drain("single");
    check("single_hold_count", int'(tap_count[1:0]), 1);

    tap_seq(0, 2, 0);
    drain("double");
    tap_seq(0, 3, 1);
    drain("triple");
    check("triple_hold_count", int'(tap_count[1:0]), 3);

    // release lands on the 4th repeat expiry: long_end only
    repeat_en = 2'b01;
    long_hold(0, 3, 40);
    drain("long_rep");

    bounce_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      btn = 2'b11;
      us(1);
      btn = 2'b00;
      us(2);
    end
    us(10);
    bounce_mode = 1'b0;
    check("bounce_busy_seen", int'(busy_seen), 0);
    drain("bounce");

    // second press exactly at gap expiry extends the sequence
    btn[0] = 1'b1;
    us(5);
    btn[0] = 1'b0;
    us(10);
    btn[0] = 1'b1;
    us(5);
    btn[0] = 1'b0;
    r = cyc;
    push(0, K_TAP, 2, r + 25, r + 28);
    drain("gap_exact");

    // one us later the gap has expired: two single taps
    btn[0] = 1'b1;
    us(5);
    btn[0] = 1'b0;
    r = cyc;
    push(0, K_TAP, 1, r + 25, r + 28);
    us(11);
    btn[0] = 1'b1;
    us(5);
    btn[0] = 1'b0;
    r = cyc;
    push(0, K_TAP, 1, r + 25, r + 28);
    drain("gap_late");

    // reset while HELD, button kept down through reset release
    repeat_en = 2'b00;
    r = cyc;
    btn[0] = 1'b1;
    push(0, K_LS, 0, r + 45, r + 48);
    wait_q("held_ls", 100);
    us(8);
    reset_p = 1'b1;
    cycles(1);
    check_zero("held_reset");
    reset_p = 1'b0;
    long_hold(0, 0, 40);
    drain("held_after_reset");

    repeat_en = 2'b01;
    fork
      long_hold(0, 3, 40);
      tap_seq(1, 2, 0);
    join
    drain("concurrent");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
